// File: rtl/stream_dedup.sv
// stream_dedup: streaming duplicate filter with a FIFO-replaced history CAM.
// Each accepted element is looked up against the last DEPTH distinct values
// and tagged unique/duplicate with a saturating per-entry hit count.
// Optional macro STREAM_DEDUP_DROP_EN: duplicates update the table and
// dup_cnt but are never forwarded to the output register.
module stream_dedup #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_dup,
  output logic [CNT_W-1:0]           out_hits,
  output logic [$clog2(DEPTH+1)-1:0] tbl_count,
  output logic [STAT_W-1:0]          uniq_cnt,
  output logic [STAT_W-1:0]          dup_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TC_W  = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [TC_W-1:0]   TC_FULL  = TC_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
`ifdef STREAM_DEDUP_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic [DEPTH-1:0]       match;
  logic [DEPTH*CNT_W-1:0] hits_flat;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic                   accept;
  logic                   hit;
  logic                   load;
  logic [CNT_W-1:0]       old_hits;
  logic [CNT_W-1:0]       new_hits;

  // A held output blocks input; clr also blocks input for its cycle.
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hit      = |match;
  assign new_hits = (old_hits == CNT_MAX) ? CNT_MAX : old_hits + CNT_W'(1);
  // Dropped duplicates are consumed but never occupy the output stage.
  assign load     = accept && !(DROP && hit);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;
      logic [CNT_W-1:0] hits_reg;

      assign match[gi] = valid_reg && (data_reg == in_data);
      assign hits_flat[gi*CNT_W +: CNT_W] = hits_reg;

      // Entry update: fill on a miss at wr_ptr, bump hit count on a match.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          hits_reg  <= '0;
        end else if (clr) begin
          valid_reg <= 1'b0;
        end else if (accept) begin
          if (!hit && wr_ptr_reg == PTR_W'(gi)) begin
            data_reg  <= in_data;
            valid_reg <= 1'b1;
            hits_reg  <= '0;
          end else if (match[gi]) begin
            hits_reg <= new_hits;
          end
        end
      end
    end
  endgenerate

  // Select the matching entry's count; at most one entry can match.
  always_comb begin
    old_hits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) old_hits = old_hits | hits_flat[i*CNT_W +: CNT_W];
    end
  end

  // Write pointer, occupancy and saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      tbl_count  <= '0;
      uniq_cnt   <= '0;
      dup_cnt    <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      tbl_count  <= '0;
      uniq_cnt   <= '0;
      dup_cnt    <= '0;
    end else if (accept) begin
      if (hit) begin
        if (dup_cnt != STAT_MAX) dup_cnt <= dup_cnt + STAT_W'(1);
      end else begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        if (tbl_count != TC_FULL) tbl_count <= tbl_count + TC_W'(1);
        if (uniq_cnt != STAT_MAX) uniq_cnt <= uniq_cnt + STAT_W'(1);
      end
    end
  end

  // Single output stage; clr leaves a pending element to finish its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dup   <= 1'b0;
      out_hits  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_dup   <= hit;
      out_hits  <= hit ? new_hits : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_dedup.md
# stream_dedup

Streaming duplicate filter with a valid/ready input and output. It keeps a history table of the last DEPTH distinct values and tags each accepted element as unique or duplicate, with a saturating per-entry hit count. Duplicates are either forwarded with a flag or dropped, depending on configuration. It is the sequential, parametrised successor to the team's combinational array dedup and sits inline on data streams ahead of packing or statistics logic.

## Interface
- WIDTH, 8, element width in bits
- DEPTH, 8, history table entries (≥2)
- CNT_W, 4, per-entry hit counter width
- STAT_W, 16, global statistics counter width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous table/stat clear
- in_valid  in  1  input element valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  WIDTH  input element
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  element
- out_dup  out  1  1 = value already present in table
- out_hits  out  CNT_W  occurrences seen before this one, saturating
- tbl_count  out  $clog2(DEPTH+1)  valid table entries
- uniq_cnt  out  STAT_W  unique elements accepted, saturating
- dup_cnt  out  STAT_W  duplicate elements accepted, saturating

## Operation
- **Accept:** accept = in_valid && in_ready.
- **Ready:** in_ready = !clr && (!out_valid || out_ready), combinational.
- **Lookup:** in_data is compared against all valid table entries in the accept cycle (parallel CAM). There is at most one match by construction.
- **Miss:**
  - Write in_data at wr_ptr, set its valid bit and its hit count to 0.
  - wr_ptr advances modulo DEPTH; tbl_count increments until it reaches DEPTH.
  - Output: out_dup=0, out_hits=0. uniq_cnt increments.
- **Hit:**
  - The matching entry's count saturates-increments, capping at 2^CNT_W−1.
  - Output: out_dup=1, out_hits = old count + 1, saturated.
  - dup_cnt increments. wr_ptr and tbl_count are unchanged.
- **Full table and miss:** the oldest entry at wr_ptr is overwritten (FIFO replacement). A later recurrence of the evicted value is reported as unique.
- **Ordering:** table update takes effect at the accept edge. The next accepted element compares against the updated table, so back-to-back equal values give unique then duplicate.
- **Statistics:** uniq_cnt and dup_cnt saturate at all-ones and never wrap.
- **clr:**
  - In the cycle clr is high: invalidate all entries, wr_ptr=0, tbl_count=0, uniq_cnt=dup_cnt=0.
  - No input is accepted that cycle.
  - The output register is not cleared; a pending out_valid element still completes its handshake.
- **Output register:** one stage. Loaded on accept, or dropped per Configuration. out_valid falls when out_valid && out_ready && no new load.

## Timing
- Latency: accept at edge N → out_valid high after edge N; element transfers at the first edge with out_ready=1.
- Throughput: one element per cycle while out_ready=1.
- Stalls: out_data, out_dup and out_hits are held stable while out_valid && !out_ready.
- Reset values:
  - out_valid=0, out_data=0, out_dup=0, out_hits=0.
  - tbl_count=0, uniq_cnt=0, dup_cnt=0, all entries invalid, wr_ptr=0.
  - in_ready=1 once rst is low and clr is low.
- Reset mid-stream: pending output and history are lost immediately (asynchronous); there is no partial handshake.
- clr together with in_valid: clr wins and the element is not accepted, because in_ready=0.

## Configuration
- Macro: STREAM_DEDUP_DROP_EN.
- **Defined:** duplicates are consumed (the table and dup_cnt are updated) but never load the output register. out_valid is asserted only for unique elements, so out_dup is always 0. in_ready still follows the rule above, so a held output stalls duplicates too.
- **Undefined:** every accepted element is forwarded with out_dup and out_hits.

## Test plan
- **Reset/idle:** assert rst mid-transfer → all outputs 0, tbl_count=0, in_ready=1 after release.
- **Basic dedup (DEPTH=4, macro off):** stream 5,7,5,5,9 with out_ready=1.
  - Outputs dup flags 0,0,1,1,0 and hits 0,0,1,2,0.
  - uniq_cnt=3, dup_cnt=2, tbl_count=3.
- **Eviction (DEPTH=4):** stream 1,2,3,4,5,1.
  - Value 5 overwrites 1; the final 1 reports out_dup=0.
  - tbl_count stays 4; uniq_cnt=6.
- **Backpressure:** out_ready=0 with 3 then 3 offered.
  - First accepted; in_ready=0 while held; out_data=3 stable.
  - After out_ready=1 the second 3 is accepted with out_dup=1.
- **Saturation (CNT_W=2):** value 8 sent 6 times → out_hits sequence 0,1,2,3,3,3.
- **Drop mode + clr (macro on):**
  - Stream 4,4,6 → output only 4,6; dup_cnt=1.
  - Pulse clr with in_valid=1, in_data=4 → not accepted. After clr, sending 4 yields a unique output and uniq_cnt=1.
